jtag_dr_sequencer: RTL and testbench
====================================

Name: jtag_dr_sequencer

Overview:
- Sequences the USER data register behind the TAP primitive for the puzzle datapath. Runs entirely in the JTAG clock domain.
- Upload direction: deserializes TDI during shift-DR into bytes (LSB first) and queues them in a small FIFO toward the solver with valid/ready.
- Readout direction: on capture-DR, snapshots the solver result plus status flags into a shift register and serializes it onto TDO.

Parameters:
- RESULT_WIDTH, 16, width of solver result word.
- FIFO_DEPTH, 4, byte FIFO entries; power of two, >=2.

Ports:
- tck  in  1  JTAG clock, sole clock.
- reset  in  1  synchronous active-high reset; driven from test_logic_reset.
- tdi  in  1  serial data in.
- tdo  out  1  serial data out.
- ir_is_user  in  1  USER instruction selected.
- capture_dr  in  1  TAP in Capture-DR.
- shift_dr  in  1  TAP in Shift-DR.
- update_dr  in  1  TAP in Update-DR.
- byte_valid  out  1  FIFO head valid.
- byte_data  out  8  FIFO head byte.
- byte_ready  in  1  consumer accepts head.
- result_data  in  RESULT_WIDTH  solver result.
- result_valid  in  1  result_data is final.
- overflow  out  1  sticky: byte lost because FIFO was full.
- framing_err  out  1  sticky: DR scan ended on a partial byte.

Behaviour:
- All state updates on rising tck. Reset is synchronous, active-high, and dominates all other inputs.
- Reset values: tdo=0, byte_valid=0, byte_data=0, overflow=0, framing_err=0. FIFO empty, bit counter 0, FSM=IDLE, readout register 0.
- Inputs are qualified by ir_is_user. capture_dr, shift_dr and update_dr are ignored when ir_is_user=0.
- FSM states:
  - IDLE -> CAPTURE on capture_dr.
  - CAPTURE -> SHIFT on shift_dr; -> UPDATE on update_dr (empty scan).
  - SHIFT stays while shift_dr; -> UPDATE on update_dr.
  - UPDATE -> IDLE next cycle, or -> CAPTURE if capture_dr is asserted.
  - Any state -> IDLE when ir_is_user deasserts; a partial byte is discarded and framing_err is set only if the bit count is nonzero.
- Capture: readout register (RESULT_WIDTH+3 bits) loads, LSB first:
  - bits [RESULT_WIDTH-1:0] = result_data
  - then result_valid
  - then overflow
  - then framing_err
  - The bit counter clears.
- Shift, each shift_dr cycle:
  - tdo <= readout[0], registered, so the first shifted cycle presents bit0.
  - Readout shifts right with 0 filling the MSB; after RESULT_WIDTH+3 shifts tdo stays 0.
  - tdi shifts into the assembly byte at bit position = counter (LSB first), and the counter increments mod 8.
  - When the counter wraps 7->0, the byte is pushed into the FIFO.
  - If the FIFO is full, the byte is dropped and overflow is set (sticky).
- Push and pop in the same cycle on a full FIFO: the pop frees a slot, so the push succeeds and no overflow is raised.
- Update: if counter != 0, set framing_err and discard the partial bits. The counter clears either way.
- Sticky flags clear only on reset.
- FIFO interface:
  - byte_valid=1 whenever non-empty; byte_data = head, held stable while byte_valid && !byte_ready.
  - Pop on byte_valid && byte_ready.
  - Push-to-visible latency is 1 cycle: byte_valid rises the cycle after the 8th bit's edge.
  - Pointers wrap mod FIFO_DEPTH; count range 0..FIFO_DEPTH.
- Simultaneous push and pop on a non-full, non-empty FIFO keeps the count constant.
- Reset mid-scan: FIFO, partial byte and flags are all lost, and tdo returns to 0 the cycle after reset.

Test Plan:
- Byte upload: capture, then shift tdi bits 0,0,1,1,1,1,0,0, with byte_ready=1 -> byte_valid pulses one cycle with byte_data=0x3C; framing_err stays 0.
- Readout: result_data=0x1234, result_valid=1, flags 0; capture then 19 shifts -> tdo bits equal 0x1234 LSB first, then 1, 0, 0; further shifts give 0.
- Overflow: byte_ready=0, shift 5 bytes 0x01..0x05 -> FIFO holds 0x01..0x04 and overflow=1. After draining, the next capture reports overflow bit=1 at position RESULT_WIDTH+1.
- Framing: shift 12 bits, then update_dr -> one byte queued, framing_err=1, and the 4 residual bits never appear.
- Full + simultaneous pop: FIFO full, byte_ready=1 on the cycle the 8th bit of a new byte lands -> overflow stays 0 and the new byte is last in order.
- Reset mid-shift: assert reset after 3 bits with 2 bytes queued -> next cycle byte_valid=0, tdo=0, flags 0; a following full scan of 0xA5 yields exactly one byte, 0xA5.

Source files
------------

// File: rtl/jtag_dr_sequencer.sv
// USER data register sequencer behind the TAP: deserializes TDI bytes into a
// small FIFO toward the solver and serializes a captured result/status word onto TDO.
module jtag_dr_sequencer #(
  parameter int unsigned RESULT_WIDTH = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic                    tck,
  input  logic                    reset,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic                    ir_is_user,
  input  logic                    capture_dr,
  input  logic                    shift_dr,
  input  logic                    update_dr,
  output logic                    byte_valid,
  output logic [7:0]              byte_data,
  input  logic                    byte_ready,
  input  logic [RESULT_WIDTH-1:0] result_data,
  input  logic                    result_valid,
  output logic                    overflow,
  output logic                    framing_err
);

  localparam int unsigned RW = RESULT_WIDTH + 3;
  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    SHIFT   = 2'd2,
    UPDATE  = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   do_capture, do_shift, do_update, do_abort;

  logic [RW-1:0] readout_q, readout_d;
  logic          tdo_q, tdo_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [7:0]    asm_q, asm_d;
  logic          ovf_q, ovf_d;
  logic          fe_q, fe_d;

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          valid_q, valid_d;
  logic [7:0]    data_q, data_d;

  logic          push, push_ok, pop;
  logic [7:0]    push_byte;

  // TAP-phase tracking; strobes are only honoured while USER is selected
  always_comb begin
    state_d    = state_q;
    do_capture = 1'b0;
    do_shift   = 1'b0;
    do_update  = 1'b0;
    do_abort   = 1'b0;
    if (!ir_is_user) begin
      state_d  = IDLE;
      do_abort = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (capture_dr) begin
            do_capture = 1'b1;
            state_d    = CAPTURE;
          end
        end
        CAPTURE, SHIFT: begin
          if (shift_dr) begin
            do_shift = 1'b1;
            state_d  = SHIFT;
          end else if (update_dr) begin
            do_update = 1'b1;
            state_d   = UPDATE;
          end
        end
        UPDATE: begin
          if (capture_dr) begin
            do_capture = 1'b1;
            state_d    = CAPTURE;
          end else begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Shift datapath, sticky flags and FIFO next-state
  always_comb begin
    readout_d = readout_q;
    tdo_d     = tdo_q;
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    ovf_d     = ovf_q;
    fe_d      = fe_q;
    push      = 1'b0;

    if (do_capture) begin
      readout_d = {fe_q, ovf_q, result_valid, result_data};
      cnt_d     = 3'd0;
    end

    if (do_shift) begin
      tdo_d        = readout_q[0];
      readout_d    = {1'b0, readout_q[RW-1:1]};
      asm_d[cnt_q] = tdi;
      cnt_d        = cnt_q + 3'(1);
      push         = (cnt_q == 3'd7);
    end
    push_byte = asm_d;

    if (do_update || do_abort) begin
      if (cnt_q != 3'd0) fe_d = 1'b1;
      cnt_d = 3'd0;
    end

    // A pop in the same cycle frees a slot for a push into a full FIFO
    pop     = valid_q && byte_ready;
    push_ok = push && ((count_q != CW'(FIFO_DEPTH)) || pop);
    if (push && !push_ok) ovf_d = 1'b1;

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    valid_d = (count_d != CW'(0));
    data_d  = data_q;
    if (valid_d) begin
      data_d = (push_ok && (wr_ptr_q == rd_ptr_d)) ? push_byte : mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge tck) begin
    if (reset) begin
      state_q   <= IDLE;
      readout_q <= '0;
      tdo_q     <= 1'b0;
      cnt_q     <= 3'd0;
      asm_q     <= 8'd0;
      ovf_q     <= 1'b0;
      fe_q      <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      data_q    <= 8'd0;
    end else begin
      state_q   <= state_d;
      readout_q <= readout_d;
      tdo_q     <= tdo_d;
      cnt_q     <= cnt_d;
      asm_q     <= asm_d;
      ovf_q     <= ovf_d;
      fe_q      <= fe_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
    end
  end

  // Storage needs no reset: entries are only read once the count covers them
  always_ff @(posedge tck) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= push_byte;
  end

  assign tdo         = tdo_q;
  assign byte_valid  = valid_q;
  assign byte_data   = data_q;
  assign overflow    = ovf_q;
  assign framing_err = fe_q;

endmodule

// File: tb/tb_jtag_dr_sequencer.sv
// Bench for jtag_dr_sequencer: directed scenarios plus randomized scans checked
// against a queue-based model of the byte stream and readout bit stream.
module tb_jtag_dr_sequencer;

  localparam int unsigned RES_W = 16;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned RW    = RES_W + 3;

  logic             tck = 1'b0;
  logic             reset = 1'b0;
  logic             tdi = 1'b0;
  logic             tdo;
  logic             ir_is_user = 1'b1;
  logic             capture_dr = 1'b0;
  logic             shift_dr = 1'b0;
  logic             update_dr = 1'b0;
  logic             byte_valid;
  logic [7:0]       byte_data;
  logic             byte_ready = 1'b0;
  logic [RES_W-1:0] result_data = '0;
  logic             result_valid = 1'b0;
  logic             overflow;
  logic             framing_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] mq[$];
  logic       rq[$];
  logic [7:0] m_byte;
  int         m_cnt;
  logic       m_ovf, m_fe, m_tdo;

  jtag_dr_sequencer #(.RESULT_WIDTH(RES_W), .FIFO_DEPTH(DEPTH)) dut (
    .tck(tck), .reset(reset), .tdi(tdi), .tdo(tdo), .ir_is_user(ir_is_user),
    .capture_dr(capture_dr), .shift_dr(shift_dr), .update_dr(update_dr),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .result_data(result_data), .result_valid(result_valid),
    .overflow(overflow), .framing_err(framing_err)
  );

  always #5 tck = ~tck;

  // One tck cycle: drive inputs, take the edge, advance the model, settle 1ns
  task automatic cyc(input logic cap, input logic sh, input logic upd,
                     input logic d, input logic rdy);
    capture_dr = cap; shift_dr = sh; update_dr = upd; tdi = d; byte_ready = rdy;
    @(posedge tck);
    if (reset) begin
      mq.delete(); rq.delete();
      m_cnt = 0; m_ovf = 1'b0; m_fe = 1'b0; m_tdo = 1'b0; m_byte = 8'd0;
    end else begin
      if (mq.size() != 0 && rdy) mq.delete(0);
      if (!ir_is_user) begin
        if (m_cnt != 0) m_fe = 1'b1;
        m_cnt = 0;
      end else begin
        if (cap) begin
          rq.delete();
          for (int i = 0; i < RES_W; i++) rq.push_back(result_data[i]);
          rq.push_back(result_valid);
          rq.push_back(m_ovf);
          rq.push_back(m_fe);
          m_cnt = 0;
        end
        if (sh) begin
          m_tdo = (rq.size() != 0) ? rq.pop_front() : 1'b0;
          m_byte[m_cnt] = d;
          m_cnt++;
          if (m_cnt == 8) begin
            if (mq.size() < DEPTH) mq.push_back(m_byte);
            else m_ovf = 1'b1;
            m_cnt = 0;
          end
        end
        if (upd) begin
          if (m_cnt != 0) m_fe = 1'b1;
          m_cnt = 0;
        end
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
    reset = 1'b0;
    checks++;
    if ({tdo, byte_valid, byte_data, overflow, framing_err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_values got tdo=%b v=%b d=%h ovf=%b fe=%b exp all 0",
               tdo, byte_valid, byte_data, overflow, framing_err);
    end
  endtask

  task automatic test_upload();
    logic [7:0] bits = 8'h3C;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, 1'b1, 1'b0, bits[i], 1'b1);
      if (i < 7) begin
        checks++;
        if (byte_valid !== 1'b0) begin
          errors++; $display("FAIL upload_early bit %0d got v=%b exp 0", i, byte_valid);
        end
      end
    end
    checks++;
    if (byte_valid !== 1'b1 || byte_data !== 8'h3C) begin
      errors++; $display("FAIL upload_byte got v=%b d=%h exp v=1 d=3c", byte_valid, byte_data);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (byte_valid !== 1'b0 || framing_err !== 1'b0) begin
      errors++; $display("FAIL upload_pulse got v=%b fe=%b exp v=0 fe=0", byte_valid, framing_err);
    end
  endtask

  task automatic test_readout();
    logic [RW-1:0] exp_bits;
    logic          e;
    result_data = 16'h1234; result_valid = 1'b1;
    exp_bits = {1'b0, 1'b0, 1'b1, 16'h1234};
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      e = (i < RW) ? exp_bits[i] : 1'b0;
      checks++;
      if (tdo !== e || tdo !== m_tdo) begin
        errors++; $display("FAIL readout_bit %0d got %b exp %b", i, tdo, e);
      end
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic test_overflow();
    logic [23:0] seen = '0;
    for (int b = 1; b <= 5; b++) begin
      if (b == 1) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, (b >> i) & 1, 1'b0);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set got %b exp 1", overflow);
    end
    for (int k = 1; k <= 4; k++) begin
      checks++;
      if (byte_valid !== 1'b1 || byte_data !== 8'(k)) begin
        errors++; $display("FAIL ovf_order %0d got v=%b d=%h exp v=1 d=%h", k, byte_valid, byte_data, 8'(k));
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (byte_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_drained got v=%b exp 0", byte_valid);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 24; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
      seen[i] = tdo;
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (seen[RES_W+1] !== 1'b1 || seen[RES_W+2] !== 1'b0) begin
      errors++; $display("FAIL ovf_readout got ovf_bit=%b fe_bit=%b exp 1 0", seen[RES_W+1], seen[RES_W+2]);
    end
  endtask

  task automatic test_framing();
    logic [7:0] b = 8'($urandom);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b1, 1'b0, (i < 8) ? b[i] : 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if (framing_err !== 1'b1 || byte_valid !== 1'b1 || byte_data !== b) begin
      errors++; $display("FAIL framing got fe=%b v=%b d=%h exp fe=1 v=1 d=%h", framing_err, byte_valid, byte_data, b);
    end
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (byte_valid !== 1'b0) begin
      errors++; $display("FAIL framing_residual got v=%b exp 0", byte_valid);
    end
  endtask

  task automatic test_full_pop();
    logic [7:0] b [5];
    do_reset();
    for (int k = 0; k < 5; k++) b[k] = 8'($urandom);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++)
      for (int i = 0; i < 8; i++)
        cyc(1'b0, 1'b1, 1'b0, b[k][i], (k == 4 && i == 7));
    checks++;
    if (overflow !== 1'b0 || byte_valid !== 1'b1 || byte_data !== b[1]) begin
      errors++; $display("FAIL full_pop got ovf=%b v=%b d=%h exp ovf=0 v=1 d=%h", overflow, byte_valid, byte_data, b[1]);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 1; k < 5; k++) begin
      checks++;
      if (byte_valid !== 1'b1 || byte_data !== b[k]) begin
        errors++; $display("FAIL full_pop_order %0d got v=%b d=%h exp v=1 d=%h", k, byte_valid, byte_data, b[k]);
      end
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    checks++;
    if (byte_valid !== 1'b0 || overflow !== 1'b0) begin
      errors++; $display("FAIL full_pop_end got v=%b ovf=%b exp 0 0", byte_valid, overflow);
    end
  endtask

  task automatic test_ir_abort();
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    ir_is_user = 1'b0;
    repeat (10) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    ir_is_user = 1'b1;
    checks++;
    if (framing_err !== 1'b1 || byte_valid !== 1'b0) begin
      errors++; $display("FAIL ir_abort got fe=%b v=%b exp fe=1 v=0", framing_err, byte_valid);
    end
  endtask

  task automatic test_random();
    int n;
    logic ev;
    do_reset();
    for (int s = 0; s < 12; s++) begin
      result_data = RES_W'($urandom); result_valid = 1'($urandom);
      cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom));
      n = $urandom_range(1, 30);
      for (int c = 0; c <= n + 3; c++) begin
        if (c < n) cyc(1'b0, 1'b1, 1'b0, 1'($urandom), ($urandom_range(0, 3) == 0));
        else if (c == n) cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom));
        else cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
        ev = (mq.size() != 0);
        checks++;
        if (byte_valid !== ev || (ev && byte_data !== mq[0]) || tdo !== m_tdo ||
            overflow !== m_ovf || framing_err !== m_fe) begin
          errors++;
          $display("FAIL rand scan %0d cyc %0d got v=%b d=%h tdo=%b ovf=%b fe=%b exp v=%b d=%h tdo=%b ovf=%b fe=%b",
                   s, c, byte_valid, byte_data, tdo, overflow, framing_err,
                   ev, ev ? mq[0] : 8'h00, m_tdo, m_ovf, m_fe);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a5 = 8'hA5;
    do_reset();
    result_data = 16'hFFFF; result_valid = 1'b1;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (19) cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (byte_valid !== 1'b1 || tdo !== 1'b0) begin
      errors++; $display("FAIL reset_mid_pre got v=%b tdo=%b exp v=1 tdo=0", byte_valid, tdo);
    end
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    reset = 1'b0;
    checks++;
    if (byte_valid !== 1'b0 || tdo !== 1'b0 || overflow !== 1'b0 || framing_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid got v=%b tdo=%b ovf=%b fe=%b exp all 0", byte_valid, tdo, overflow, framing_err);
    end
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b1, 1'b0, a5[i], 1'b0);
    checks++;
    if (byte_valid !== 1'b1 || byte_data !== 8'hA5) begin
      errors++; $display("FAIL reset_mid_a5 got v=%b d=%h exp v=1 d=a5", byte_valid, byte_data);
    end
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    checks++;
    if (byte_valid !== 1'b0 || framing_err !== 1'b0) begin
      errors++; $display("FAIL reset_mid_single got v=%b fe=%b exp 0 0", byte_valid, framing_err);
    end
  endtask

  initial begin
    m_cnt = 0; m_ovf = 1'b0; m_fe = 1'b0; m_tdo = 1'b0; m_byte = 8'd0;
    test_reset();
    test_upload();
    test_readout();
    test_overflow();
    test_framing();
    test_full_pop();
    test_ir_abort();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
